// File: rtl/jts16_snd_bridge.sv
// Sound-command bridge from the main CPU 8255 to the Z80 sound CPU.
// A falling snd_irqn edge captures the command and pulses the Z80 NMI; the Z80 releases the latch by reading it.
module jts16_snd_bridge #(
    parameter logic [7:0] NMI_LEN  = 8'd8,
    parameter logic [1:0] PORT_SEL = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [7:0] snd_latch,
    input  logic       snd_irqn,
    input  logic [7:0] z80_addr,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       m1_n,
    output logic       nmi_n,
    output logic       latch_cs,
    output logic [7:0] latch_dout,
    output logic       snd_ack,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dout_q, dout_d;
    logic       irqn_last_q, irqn_last_d;
    logic       cs_last_q, cs_last_d;
    logic       nmi_n_q, nmi_n_d;
    logic       ack_q, ack_d;
    logic       ovr_q, ovr_d;
    logic       consumed_q, consumed_d;
    logic       fall, rd_ev;

    // M1 low with IORQ low is an interrupt acknowledge, never a port read
    assign latch_cs   = ~iorq_n & ~rd_n & m1_n & (z80_addr[7:6] == PORT_SEL);
    assign fall       = irqn_last_q & ~snd_irqn;
    assign rd_ev      = latch_cs & ~cs_last_q;

    assign nmi_n      = nmi_n_q;
    assign latch_dout = dout_q;
    assign snd_ack    = ack_q;
    assign overrun    = ovr_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        irqn_last_d = snd_irqn;
        cs_last_d   = latch_cs;
        nmi_n_d     = nmi_n_q;
        ack_d       = ack_q;
        ovr_d       = ovr_q;
        consumed_d  = consumed_q;
        if (fall) begin
            // A new command beats a same-clock read; the byte being read is not lost
            dout_d     = snd_latch;
            cnt_d      = NMI_LEN;
            state_d    = PULSE;
            nmi_n_d    = 1'b0;
            ack_d      = 1'b0;
            consumed_d = 1'b0;
            if (state_q != IDLE && !rd_ev && !consumed_q)
                ovr_d = 1'b1;
        end else begin
            case (state_q)
                PULSE: begin
                    if (rd_ev)
                        consumed_d = 1'b1;
                    if (cen) begin
                        if (cnt_q == 8'd1) begin
                            nmi_n_d    = 1'b1;
                            consumed_d = 1'b0;
                            if (consumed_q || rd_ev) begin
                                state_d = IDLE;
                                ack_d   = 1'b1;
                            end else begin
                                state_d = WAIT;
                            end
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                WAIT: begin
                    if (rd_ev) begin
                        state_d = IDLE;
                        ack_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            dout_q      <= 8'h00;
            irqn_last_q <= 1'b1;
            cs_last_q   <= 1'b0;
            nmi_n_q     <= 1'b1;
            ack_q       <= 1'b1;
            ovr_q       <= 1'b0;
            consumed_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            irqn_last_q <= irqn_last_d;
            cs_last_q   <= cs_last_d;
            nmi_n_q     <= nmi_n_d;
            ack_q       <= ack_d;
            ovr_q       <= ovr_d;
            consumed_q  <= consumed_d;
        end
    end

endmodule

// File: tb/tb_jts16_snd_bridge.sv
// Directed bench for jts16_snd_bridge: handshake, overrun, IACK filtering, early read, collision, async reset.
module tb_jts16_snd_bridge;

    logic       clk = 1'b0, rst = 1'b1, cen = 1'b0;
    logic [7:0] snd_latch = 8'h00, z80_addr = 8'h00;
    logic       snd_irqn = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, m1_n = 1'b1;
    logic       nmi_n, latch_cs, snd_ack, overrun;
    logic [7:0] latch_dout;

    int checks = 0, errors = 0;
    int lo_cnt = 0, mark = 0;

    jts16_snd_bridge #(.NMI_LEN(8'd8), .PORT_SEL(2'b11)) dut (
        .clk(clk), .rst(rst), .cen(cen), .snd_latch(snd_latch), .snd_irqn(snd_irqn),
        .z80_addr(z80_addr), .iorq_n(iorq_n), .rd_n(rd_n), .m1_n(m1_n),
        .nmi_n(nmi_n), .latch_cs(latch_cs), .latch_dout(latch_dout),
        .snd_ack(snd_ack), .overrun(overrun)
    );

    always #5 clk = ~clk;
    // cen active every other clk so the pulse counter must honour the enable
    always @(posedge clk) begin #2; cen = ~cen; end
    // count cen ticks seen with NMI low
    always @(negedge clk) if (cen && !nmi_n) lo_cnt++;

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        snd_irqn = 1'b1;
        step();
        snd_latch = d;
        snd_irqn  = 1'b0;
        step();
        mark = lo_cnt;
    endtask

    task automatic wait_nmi_high(input string tag);
        int n = 0;
        while (!nmi_n && n < 200) begin step(); n++; end
        chk({tag, "_timeout"}, 32'(n < 200), 32'd1);
    endtask

    task automatic wait_ticks(input string tag, input int t);
        int n = 0;
        while ((lo_cnt - mark) < t && n < 200) begin step(); n++; end
        chk({tag, "_timeout"}, 32'(n < 200), 32'd1);
    endtask

    task automatic rd_start(input logic [7:0] a, input logic m1);
        z80_addr = a;
        m1_n     = m1;
        iorq_n   = 1'b0;
        rd_n     = 1'b0;
    endtask

    task automatic rd_end();
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        m1_n   = 1'b1;
    endtask

    initial begin
        step(2);
        chk("rst_nmi", 32'(nmi_n), 32'd1);
        chk("rst_dout", 32'(latch_dout), 32'h00);
        chk("rst_cs", 32'(latch_cs), 32'd0);
        chk("rst_ack", 32'(snd_ack), 32'd1);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        step();

        // basic handshake
        send(8'h5A);
        chk("b_dout", 32'(latch_dout), 32'h5A);
        chk("b_ack0", 32'(snd_ack), 32'd0);
        chk("b_nmi0", 32'(nmi_n), 32'd0);
        wait_nmi_high("b_pulse");
        chk("b_ticks", 32'(lo_cnt - mark), 32'd8);
        chk("b_wait_ack", 32'(snd_ack), 32'd0);
        rd_start(8'hC0, 1'b1);
        #1;
        chk("b_cs", 32'(latch_cs), 32'd1);
        chk("b_rd_dout", 32'(latch_dout), 32'h5A);
        step();
        chk("b_ack1", 32'(snd_ack), 32'd1);
        rd_end();
        step();

        // fall and read in the same clk: fall wins, no overrun
        send(8'h66);
        wait_nmi_high("c_pulse");
        snd_irqn = 1'b1;
        step();
        snd_latch = 8'h33;
        snd_irqn  = 1'b0;
        rd_start(8'hC0, 1'b1);
        step();
        mark = lo_cnt;
        rd_end();
        chk("c_nmi0", 32'(nmi_n), 32'd0);
        chk("c_ack0", 32'(snd_ack), 32'd0);
        chk("c_dout", 32'(latch_dout), 32'h33);
        chk("c_ovr", 32'(overrun), 32'd0);
        wait_nmi_high("c_pulse2");
        chk("c_wait_ack", 32'(snd_ack), 32'd0);
        rd_start(8'hC0, 1'b1);
        step();
        rd_end();
        chk("c_ack1", 32'(snd_ack), 32'd1);
        step();

        // early read during the pulse
        send(8'h55);
        wait_ticks("e_t3", 3);
        rd_start(8'hC0, 1'b1);
        step();
        rd_end();
        chk("e_nmi_still0", 32'(nmi_n), 32'd0);
        chk("e_ack_still0", 32'(snd_ack), 32'd0);
        wait_nmi_high("e_pulse");
        chk("e_ticks", 32'(lo_cnt - mark), 32'd8);
        chk("e_ack_end", 32'(snd_ack), 32'd1);
        rd_start(8'hC0, 1'b1);
        step();
        rd_end();
        step();
        chk("e_late_ack", 32'(snd_ack), 32'd1);
        chk("e_late_nmi", 32'(nmi_n), 32'd1);

        // interrupt acknowledge and wrong port must not read the latch
        send(8'h44);
        wait_nmi_high("i_pulse");
        rd_start(8'hC0, 1'b0);
        #1;
        chk("i_cs", 32'(latch_cs), 32'd0);
        step(3);
        chk("i_ack", 32'(snd_ack), 32'd0);
        chk("i_nmi", 32'(nmi_n), 32'd1);
        rd_end();
        rd_start(8'h80, 1'b1);
        #1;
        chk("i_port_cs", 32'(latch_cs), 32'd0);
        step(2);
        chk("i_port_ack", 32'(snd_ack), 32'd0);
        rd_end();
        step();
        rd_start(8'hFF, 1'b1);
        step();
        rd_end();
        chk("i_rd_ack", 32'(snd_ack), 32'd1);
        step();

        // overrun: second command before any read
        send(8'h11);
        wait_ticks("o_t3", 3);
        send(8'h22);
        chk("o_ovr", 32'(overrun), 32'd1);
        chk("o_dout", 32'(latch_dout), 32'h22);
        chk("o_nmi0", 32'(nmi_n), 32'd0);
        wait_nmi_high("o_pulse");
        chk("o_ticks", 32'(lo_cnt - mark), 32'd8);
        chk("o_wait_ack", 32'(snd_ack), 32'd0);
        rd_start(8'hC0, 1'b1);
        step();
        rd_end();
        chk("o_ack1", 32'(snd_ack), 32'd1);
        step();
        chk("o_ovr_sticky", 32'(overrun), 32'd1);

        // asynchronous reset mid-pulse
        send(8'h77);
        wait_ticks("r_t4", 4);
        #2;
        rst      = 1'b1;
        snd_irqn = 1'b1;
        #1;
        chk("r_nmi", 32'(nmi_n), 32'd1);
        chk("r_ack", 32'(snd_ack), 32'd1);
        chk("r_dout", 32'(latch_dout), 32'h00);
        chk("r_ovr", 32'(overrun), 32'd0);
        step();
        rst = 1'b0;
        step();
        send(8'h88);
        chk("r2_dout", 32'(latch_dout), 32'h88);
        chk("r2_ack0", 32'(snd_ack), 32'd0);
        wait_nmi_high("r2_pulse");
        chk("r2_ticks", 32'(lo_cnt - mark), 32'd8);
        chk("r2_ovr", 32'(overrun), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
